// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the Integrate CPU host I/O port.
package cpu_io_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    FEED_IDLE    = 2'd0,
    FEED_PRESENT = 2'd1,
    FEED_RELEASE = 2'd2
  } feed_state_e;

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO; a pop and a push in the same cycle are both
// honoured, even when full.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_io_host.sv
// Host-side I/O port for the Integrate CPU: feeds queued operands through the
// Nin/enter handshake and captures every Nout change into an output queue.
module cpu_io_host
  import cpu_io_pkg::*;
#(
  parameter int          IN_DEPTH    = 4,
  parameter int          OUT_DEPTH   = 4,
  parameter logic [3:0]  INPUT_STATE = 4'd3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic [DATA_W-1:0] Nin,
  output logic              enter,
  input  logic [3:0]        StateNoin,
  input  logic [DATA_W-1:0] Nout,
  input  logic              halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              done,
  output logic              underrun,
  output logic              overrun,
  output logic [7:0]        in_count,
  output feed_state_e       feed_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // push_ready depends only on the input queue being not full, and out_valid
  // only on the output queue being not empty.

  feed_state_e       state_q, state_d;
  logic [DATA_W-1:0] nin_q, nout_q;
  logic [7:0]        in_count_q;
  logic              done_q, underrun_q, overrun_q;

  logic              in_full, in_empty, in_push, in_pop;
  logic [DATA_W-1:0] in_head;
  logic              out_full, out_empty, out_push, out_pop;
  logic              waiting, stop, underrun_set, overrun_set, nout_changed;

  io_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (in_push),
    .wdata_i (push_data),
    .pop_i   (in_pop),
    .rdata_o (in_head),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  io_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (out_push),
    .wdata_i (Nout),
    .pop_i   (out_pop),
    .rdata_o (out_data),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  assign push_ready = !in_full;
  assign in_push    = push_valid && push_ready;
  assign in_pop     = (state_q == FEED_PRESENT);
  assign waiting    = (StateNoin == INPUT_STATE);
  // A halt seen this cycle already blocks a new delivery.
  assign stop       = done_q || halt;

  always_comb begin
    state_d      = state_q;
    underrun_set = 1'b0;
    unique case (state_q)
      FEED_IDLE: begin
        if (waiting && !stop) begin
          if (!in_empty) state_d = FEED_PRESENT;
          else           underrun_set = 1'b1;
        end
      end
      FEED_PRESENT: state_d = FEED_RELEASE;
      // Wait for the CPU to leave its input state so one episode gets one value.
      FEED_RELEASE: if (!waiting) state_d = FEED_IDLE;
      default:      state_d = FEED_IDLE;
    endcase
  end

  assign out_valid    = !out_empty;
  assign out_pop      = out_valid && out_ready;
  assign nout_changed = (Nout != nout_q);
  assign out_push     = nout_changed && (!out_full || out_pop);
  assign overrun_set  = nout_changed && out_full && !out_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FEED_IDLE;
      nin_q      <= '0;
      nout_q     <= '0;
      in_count_q <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FEED_IDLE && state_d == FEED_PRESENT) nin_q <= in_head;
      if (in_pop)       in_count_q <= in_count_q + 8'd1;
      if (underrun_set) underrun_q <= 1'b1;
      if (overrun_set)  overrun_q  <= 1'b1;
      if (halt)         done_q     <= 1'b1;
      nout_q <= Nout;
    end
  end

  assign enter        = (state_q == FEED_PRESENT);
  assign Nin          = nin_q;
  assign in_count     = in_count_q;
  assign done         = done_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign feed_state_o = state_q;

endmodule

// File: tb/tb_cpu_io_host.sv
// Directed bench for cpu_io_host with a queue-based reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_cpu_io_host;
  import cpu_io_pkg::*;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        push_valid = 1'b0;
  logic [7:0]  push_data = '0;
  logic        push_ready;
  logic [7:0]  Nin;
  logic        enter;
  logic [3:0]  StateNoin = '0;
  logic [7:0]  Nout = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        done, underrun, overrun;
  logic [7:0]  in_count;
  feed_state_e feed_state;

  cpu_io_host #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .INPUT_STATE(4'd3)) dut (
    .clock        (clock),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .Nin          (Nin),
    .enter        (enter),
    .StateNoin    (StateNoin),
    .Nout         (Nout),
    .halt         (halt),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .done         (done),
    .underrun     (underrun),
    .overrun      (overrun),
    .in_count     (in_count),
    .feed_state_o (feed_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_nin, m_cnt, m_last;
  bit m_enter, m_armed, m_done, m_under, m_over, m_valid;
  bit s_in_push, s_out_pop;

  initial begin
    m_valid = 0;
    m_enter = 0;
    m_armed = 1;
    m_done = 0; m_under = 0; m_over = 0;
    m_nin = '0; m_cnt = '0; m_last = '0;
  end

  // One operand per CPU wait episode: after a delivery the model is disarmed
  // until the CPU is seen outside its input state.
  always @(posedge clock) begin
    if (reset) begin
      in_q.delete();
      exp_q.delete();
      m_nin = '0; m_cnt = '0; m_last = '0;
      m_enter = 0; m_armed = 1;
      m_done = 0; m_under = 0; m_over = 0;
    end else begin
      s_in_push = push_valid && (in_q.size() < IN_DEPTH);
      s_out_pop = out_ready && (exp_q.size() > 0);
      if (m_enter) begin
        void'(in_q.pop_front());
        m_cnt   = m_cnt + 8'd1;
        m_enter = 0;
        m_armed = 0;
      end else if (!m_armed) begin
        if (StateNoin != 4'd3) m_armed = 1;
      end else if (StateNoin == 4'd3 && !(m_done || halt)) begin
        if (in_q.size() > 0) begin
          m_enter = 1;
          m_nin   = in_q[0];
        end else begin
          m_under = 1;
        end
      end
      if (s_in_push) in_q.push_back(push_data);
      if (s_out_pop) void'(exp_q.pop_front());
      if (Nout != m_last) begin
        if (exp_q.size() < OUT_DEPTH) exp_q.push_back(Nout);
        else                          m_over = 1;
        m_last = Nout;
      end
      if (halt) m_done = 1;
    end
    m_valid = 1;
  end

  // ---------------- scoreboard compare ----------------
  int         enter_cnt = 0;
  logic [7:0] seen_nin[$];

  always @(negedge clock) begin
    if (m_valid) begin
      chk1("push_ready", push_ready, in_q.size() < IN_DEPTH);
      chk1("enter", enter, m_enter);
      chk("Nin", Nin, m_nin);
      chk1("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
      chk1("done", done, m_done);
      chk1("underrun", underrun, m_under);
      chk1("overrun", overrun, m_over);
      chk("in_count", in_count, m_cnt);
      if (enter === 1'b1) begin
        enter_cnt++;
        seen_nin.push_back(Nin);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_op(input logic [7:0] v);
    push_valid = 1'b1;
    push_data  = v;
    step();
    push_valid = 1'b0;
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values();
    chk1("rst push_ready", push_ready, 1'b1);
    chk("rst Nin", Nin, 8'd0);
    chk1("rst enter", enter, 1'b0);
    chk1("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 8'd0);
    chk1("rst done", done, 1'b0);
    chk1("rst underrun", underrun, 1'b0);
    chk1("rst overrun", overrun, 1'b0);
    chk("rst in_count", in_count, 8'd0);
    chk1("rst feed_idle", feed_state == FEED_IDLE, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  logic [7:0] t1_vals [3];

  initial begin
    t1_vals = '{8'd9, 8'd5, 8'd3};
    step(2);
    check_reset_values();
    reset = 1'b0;
    step();

    // Three operands over three wait episodes.
    foreach (t1_vals[i]) push_op(t1_vals[i]);
    enter_cnt = 0;
    seen_nin.delete();
    for (int e = 0; e < 3; e++) begin
      StateNoin = 4'd3;
      step(3);
      StateNoin = 4'd0;
      step(7);
    end
    chk("t1 enter pulses", 8'(enter_cnt), 8'd3);
    chk("t1 delivered count", 8'(seen_nin.size()), 8'd3);
    if (seen_nin.size() == 3) begin
      chk("t1 nin0", seen_nin[0], 8'd9);
      chk("t1 nin1", seen_nin[1], 8'd5);
      chk("t1 nin2", seen_nin[2], 8'd3);
    end
    chk("t1 in_count", in_count, 8'd3);
    chk("t1 Nin held", Nin, 8'd3);

    // Long wait episode: only one delivery.
    push_op(8'd1);
    push_op(8'd2);
    enter_cnt = 0;
    StateNoin = 4'd3;
    step(20);
    chk("t2 single enter", 8'(enter_cnt), 8'd1);
    chk("t2 Nin", Nin, 8'd1);
    chk("t2 in_count", in_count, 8'd4);
    StateNoin = 4'd0;
    step(2);
    StateNoin = 4'd3;
    step(3);
    chk("t2 leftover enter", 8'(enter_cnt), 8'd2);
    chk("t2 leftover Nin", Nin, 8'd2);
    StateNoin = 4'd0;
    step(2);

    // Underrun, then late operand.
    enter_cnt = 0;
    StateNoin = 4'd3;
    step(3);
    chk1("t3 underrun", underrun, 1'b1);
    chk("t3 no enter", 8'(enter_cnt), 8'd0);
    push_op(8'd7);
    chk1("t3 enter after write edge", enter, 1'b0);
    step();
    chk1("t3 enter after fsm edge", enter, 1'b1);
    chk("t3 Nin", Nin, 8'd7);
    StateNoin = 4'd0;
    step(3);
    chk("t3 in_count", in_count, 8'd6);

    // Output capture with repeated value.
    Nout = 8'd12; step();
    Nout = 8'd12; step();
    Nout = 8'd40; step();
    step();
    chk1("t4 out_valid", out_valid, 1'b1);
    chk("t4 head0", out_data, 8'd12);
    pop_out();
    chk("t4 head1", out_data, 8'd40);
    pop_out();
    chk1("t4 drained", out_valid, 1'b0);

    // Output overrun, then the same with a concurrent pop.
    for (int i = 1; i <= 4; i++) begin
      Nout = 8'(i);
      step();
    end
    chk1("t5 no overrun when just full", overrun, 1'b0);
    Nout = 8'd5;
    step();
    chk1("t5 overrun", overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5 contents", out_data, 8'(i));
      pop_out();
    end
    chk1("t5 drained", out_valid, 1'b0);

    Nout  = 8'd0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step();
    for (int i = 6; i <= 9; i++) begin
      Nout = 8'(i);
      step();
    end
    Nout = 8'd10;
    pop_out();
    chk1("t5b no overrun", overrun, 1'b0);
    for (int i = 7; i <= 10; i++) begin
      chk("t5b contents", out_data, 8'(i));
      pop_out();
    end

    // Halt blocks delivery; capture keeps working.
    push_op(8'd11);
    enter_cnt = 0;
    StateNoin = 4'd3;
    halt = 1'b1;
    step(5);
    chk1("t6 done", done, 1'b1);
    chk("t6 no enter", 8'(enter_cnt), 8'd0);
    halt = 1'b0;
    StateNoin = 4'd0;
    step(2);
    StateNoin = 4'd3;
    step(4);
    chk("t6 still no enter", 8'(enter_cnt), 8'd0);
    chk("t6 in_count", in_count, 8'd0);
    Nout = 8'd77;
    step();
    chk1("t6 capture valid", out_valid, 1'b1);
    chk("t6 capture data", out_data, 8'd77);
    StateNoin = 4'd0;

    // Reset in the middle of a delivery.
    reset = 1'b1;
    Nout  = 8'd0;
    step();
    reset = 1'b0;
    push_op(8'd13);
    StateNoin = 4'd3;
    step();
    chk1("t7 presenting", enter, 1'b1);
    chk("t7 Nin", Nin, 8'd13);
    reset = 1'b1;
    step();
    check_reset_values();
    reset = 1'b0;
    StateNoin = 4'd0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
